// File: rtl/dmi_arb_pkg.sv
// Shared types and constants for the DMI requester arbiter.
// ABITS falls back to the standard 7-bit DMI address when the build does not define it.
`ifndef ABITS
`define ABITS 7
`endif

package dmi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    localparam logic [31:0] DMI_ERR_DATA = 32'hDEAD_BEEF;

    // Index type covers the largest supported requester count.
    localparam int NREQ_MAX = 4;
    typedef logic [$clog2(NREQ_MAX)-1:0] req_idx_t;

endpackage

// File: rtl/dmi_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr, with wrap.
module rr_arbiter
    import dmi_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  req_idx_t        ptr,
    output logic            any,
    output req_idx_t        grant_idx
);

    always_comb begin
        logic [NREQ-1:0] rot;
        int              sum;
        rot       = NREQ'({req, req} >> ptr);
        any       = 1'b0;
        sum       = 0;
        grant_idx = '0;
        // Descending scan so the lowest rotated position (closest to ptr) wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                sum = int'(ptr) + k;
            end
        end
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        grant_idx = req_idx_t'(sum);
    end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares one DMI slave port between NREQ requesters: round-robin, one transaction
// in flight, registered response, timeout completion when the DM never answers.
module dmi_arbiter
    import dmi_arb_pkg::*;
#(
    parameter int ABITS   = `ABITS,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0]             req_write_en,
    input  logic [NREQ-1:0][ABITS-1:0]  req_addr,
    input  logic [NREQ-1:0][31:0]       req_wdata,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0][31:0]       req_rdata,
    output logic [NREQ-1:0]             req_err,
    output logic                        dm_valid,
    output logic                        dm_write_en,
    output logic [ABITS-1:0]            dm_addr,
    output logic [31:0]                 dm_wdata,
    input  logic                        dm_ready,
    input  logic [31:0]                 dm_rdata,
    output logic                        busy
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_e             state_q, state_d;
    req_idx_t               ptr_q, ptr_d;
    req_idx_t               grant_q, grant_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NREQ-1:0][31:0]  rdata_q, rdata_d;
    logic [NREQ-1:0]        err_q, err_d;
    logic [NREQ-1:0]        ready_q, ready_d;
    logic                   dm_valid_q, dm_valid_d;

    logic                   arb_any;
    req_idx_t               arb_idx;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .any       (arb_any),
        .grant_idx (arb_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ready_d    = '0;
        dm_valid_d = dm_valid_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d    = arb_idx;
                    cnt_d      = '0;
                    dm_valid_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (dm_ready || cnt_q == CNT_LAST) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant_q == req_idx_t'(i)) begin
                            rdata_d[i] = dm_ready ? dm_rdata : DMI_ERR_DATA;
                            err_d[i]   = !dm_ready;
                            ready_d[i] = 1'b1;
                        end
                    end
                    dm_valid_d = 1'b0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                ptr_d   = (grant_q == req_idx_t'(NREQ - 1)) ? '0 : grant_q + req_idx_t'(1);
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                dm_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= '0;
            ready_q    <= '0;
            dm_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            dm_valid_q <= dm_valid_d;
        end
    end

    // DM-side request fields follow the granted requester live; zero when idle.
    always_comb begin
        dm_addr     = '0;
        dm_wdata    = '0;
        dm_write_en = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (dm_valid_q && grant_q == req_idx_t'(i)) begin
                dm_addr     = req_addr[i];
                dm_wdata    = req_wdata[i];
                dm_write_en = req_write_en[i];
            end
        end
    end

    assign dm_valid  = dm_valid_q;
    assign req_ready = ready_q;
    assign req_rdata = rdata_q;
    assign req_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
- Shares the single DMI slave port of the debug module between NREQ requesters, e.g. the JTAG DTM and a UART/host debug bridge.
- Round-robin arbitration, one outstanding transaction at a time.
- Registers the response back to the winning requester; bounds every transaction with a timeout so a missing DM ready cannot hang a host.
- Sits between the requesters and the debug module's DMIPort.Slave.

Parameters:
- ABITS, `ABITS, DMI address width.
- NREQ, 2, number of requesters (2..4).
- TIMEOUT, 64, max cycles in ISSUE waiting for dm_ready before error completion (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request; held stable until its req_ready
- req_write_en  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ x ABITS  request address
- req_wdata  in  NREQ x 32  write data
- req_ready  out  NREQ  one-cycle completion pulse to the granted requester
- req_rdata  out  NREQ x 32  response data, valid while req_ready
- req_err  out  NREQ  timeout flag, valid while req_ready
- dm_valid  out  1  DMI request to debug module
- dm_write_en  out  1  DMI write enable
- dm_addr  out  ABITS  DMI address
- dm_wdata  out  32  DMI write data
- dm_ready  in  1  DMI completion, same cycle as dm_valid when accepted
- dm_rdata  in  32  DMI read data, valid with dm_ready
- busy  out  1  high in ISSUE or RESP

Behaviour:
- Reset: state IDLE, rr pointer 0, grant 0, timeout counter 0.
  - All req_ready, req_err, dm_valid and busy are 0; req_rdata, dm_addr and dm_wdata are 0.
  - Reset mid-transaction aborts it; no ready pulse is issued.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning from the rr pointer upward with wrap.
  - Register grant; go to ISSUE; clear the counter.
- ISSUE:
  - dm_valid=1; dm_addr, dm_wdata and dm_write_en come combinationally from the granted requester's inputs.
  - If dm_ready: capture dm_rdata into the granted req_rdata register, set req_err=0, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 without dm_ready: req_rdata=32'hDEAD_BEEF, req_err=1, go to RESP.
  - The DM-side write occurs only on a dm_valid&&dm_ready cycle.
- RESP:
  - req_ready[grant]=1 for exactly this cycle; dm_valid=0.
  - rr pointer becomes (grant+1) mod NREQ; go to IDLE.
- Latency: req_valid first seen in IDLE at cycle t -> dm_valid at t+1 -> with immediate dm_ready, req_ready at t+2. Back-to-back requests from one requester therefore take 3 cycles each.
- req_valid still high in the IDLE cycle after a RESP is a new request.
- A requester dropping req_valid during ISSUE is ignored; the transaction completes.
- Simultaneous requests: rr pointer order. A requester that just completed has lowest priority next arbitration, so no requester starves.
- req_rdata and req_err of non-granted requesters hold their last values; their req_ready stays 0.
- Only one dm_valid burst is in flight; no pipelining.

Decomposition:
- Shared package dmi_arb_pkg: state enum (IDLE, ISSUE, RESP), DMI_ERR_DATA = 32'hDEAD_BEEF, requester index type sized $clog2(NREQ).
- One sub-module: rr_arbiter (NREQ request vector + pointer -> one-hot/indexed grant, purely combinational). Timer and FSM stay in dmi_arbiter.

Test Plan:
- Single read: req0 read addr 0x11 with dm_ready=1 and dm_rdata=0x0000_0382 -> dm_valid at t+1 with addr 0x11; req_ready[0] at t+2 with rdata 0x382, err 0.
- Contention: req0 and req1 valid together at reset (ptr 0) -> req0 served first. Then req1 served, with req_ready[1] 3 cycles after req_ready[0]; the next simultaneous pair grants req0 again.
- Write passthrough: req1 write addr 0x10 wdata 0x8000_0001 -> exactly one dm_valid cycle with dm_write_en=1 and those values; req_ready[1] 1 cycle later.
- Timeout: dm_ready held 0, TIMEOUT=64 -> dm_valid high for 64 cycles, then req_ready[0]=1 with rdata 0xDEAD_BEEF, err 1; busy falls the next cycle.
- Reset mid-ISSUE: assert rst during dm_valid -> the next cycle dm_valid=0, no req_ready pulse, ptr 0; a fresh request then completes normally.
- Fairness: req0 valid continuously, req1 valid continuously -> grants strictly alternate 0,1,0,1 across 8 transactions.
